// File: rtl/divider_ctrl_if.sv
// Configuration handshake, run control and status bundle for divider_ctrl.
// The slave modport is the controller side; the master modport is the side that drives it.
interface divider_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_burst;
  logic             start;
  logic             stop;
  logic             tick;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] tick_count;

  modport master (
    output cfg_valid, cfg_div, cfg_burst, start, stop,
    input  cfg_ready, tick, busy, done, tick_count
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_burst, start, stop,
    output cfg_ready, tick, busy, done, tick_count
  );
endinterface

// File: rtl/divider_ctrl.sv
// Programmable divide-by-N tick generator: a configurable clock-enable source
// with burst length, stop/abort, busy/done status and a running tick count.
//
// state | meaning
// IDLE  | accepting configuration, waiting for start
// RUN   | issuing a tick every max(div_q,1) cycles
// DONE  | one-cycle done pulse after a burst completes normally
module divider_ctrl #(
  parameter int WIDTH       = 8,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 3
) (
  input  logic           clk,
  input  logic           reset,
  divider_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]       state;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] phase;
  logic [WIDTH-1:0] ne;
  logic [WIDTH-1:0] phase_last;
  logic [CNT_W-1:0] burst_q;
  logic [CNT_W-1:0] tick_count;
  logic             tick_w;
  logic             cfg_fire;
  logic             burst_end;

  // A divisor of 0 behaves like 1: tick every cycle.
  assign ne         = (div_q == '0) ? WIDTH'(1) : div_q;
  assign phase_last = ne - WIDTH'(1);

  assign tick_w    = (state == RUN) && (phase == '0);
  assign cfg_fire  = bus.cfg_valid && (state == IDLE);
  assign burst_end = (burst_q != '0) && tick_w &&
                     (({1'b0, tick_count} + (CNT_W+1)'(1)) == {1'b0, burst_q});

  assign bus.tick       = tick_w;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.cfg_ready  = (state == IDLE);
  assign bus.tick_count = tick_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div_q      <= WIDTH'(DEFAULT_DIV);
      burst_q    <= '0;
      phase      <= '0;
      tick_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_fire) begin
            div_q   <= bus.cfg_div;
            burst_q <= bus.cfg_burst;
          end
          if (bus.start) begin
            state      <= RUN;
            phase      <= '0;
            tick_count <= '0;
          end
        end
        RUN: begin
          phase <= (phase >= phase_last) ? '0 : phase + WIDTH'(1);
          if (tick_w && (tick_count != '1))
            tick_count <= tick_count + CNT_W'(1);
          // Stop wins over burst completion; a coincident tick is still counted.
          if (bus.stop)
            state <= IDLE;
          else if (burst_end)
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// Bench for divider_ctrl: directed scenarios followed by random stimulus, checked
// every cycle against a run-level behavioural model.
module tb_divider_ctrl;
  localparam int WIDTH       = 8;
  localparam int CNT_W       = 16;
  localparam int DEFAULT_DIV = 3;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  divider_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  divider_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: a run is "running" for t cycles since start; a tick lands whenever
  // t is a multiple of the effective divisor.
  bit m_valid = 1'b0;
  bit m_run;
  bit m_done;
  int m_t;
  int m_div;
  int m_burst;
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic bit model_tick();
    int ne;
    ne = (m_div < 1) ? 1 : m_div;
    return m_run && ((m_t % ne) == 0);
  endfunction

  task automatic check_outputs();
    chk("tick",       {31'd0, bus.tick},      {31'd0, model_tick()});
    chk("done",       {31'd0, bus.done},      {31'd0, m_done});
    chk("busy",       {31'd0, bus.busy},      {31'd0, (m_run || m_done)});
    chk("cfg_ready",  {31'd0, bus.cfg_ready}, {31'd0, !(m_run || m_done)});
    chk("tick_count", {16'd0, bus.tick_count}, m_cnt);
  endtask

  task automatic model_update();
    bit tk;
    tk = model_tick();
    if (reset) begin
      m_valid = 1'b1;
      m_run   = 1'b0;
      m_done  = 1'b0;
      m_t     = 0;
      m_div   = DEFAULT_DIV;
      m_burst = 0;
      m_cnt   = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_run) begin
      if (tk && m_cnt < CNT_MAX) m_cnt++;
      if (bus.stop) m_run = 1'b0;
      else if (m_burst != 0 && tk && m_cnt == m_burst) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end else m_t++;
    end else begin
      if (bus.cfg_valid) begin
        m_div   = int'(bus.cfg_div);
        m_burst = int'(bus.cfg_burst);
      end
      if (bus.start) begin
        m_run = 1'b1;
        m_t   = 0;
        m_cnt = 0;
      end
    end
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance the model.
  task automatic cyc(input bit r, input bit st, input bit sp, input bit cv,
                     input int d, input int b);
    reset         = r;
    bus.start     = st;
    bus.stop      = sp;
    bus.cfg_valid = cv;
    bus.cfg_div   = WIDTH'(d);
    bus.cfg_burst = CNT_W'(b);
    @(negedge clk);
    if (m_valid) check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(2);

    // Defaults: div 3, continuous.
    cyc(0, 1, 0, 0, 0, 0);
    idle(12);
    cyc(0, 0, 1, 0, 0, 0);
    idle(3);

    // Config + start together: div 5, burst 2.
    cyc(0, 1, 0, 1, 5, 2);
    idle(10);

    // div 0 means every cycle, burst 3.
    cyc(0, 0, 0, 1, 0, 3);
    cyc(0, 1, 0, 0, 0, 0);
    idle(6);

    // div 4 continuous, stop on the 3rd tick (cycle 9 after start).
    cyc(0, 1, 0, 1, 4, 0);
    idle(8);
    cyc(0, 0, 1, 0, 0, 0);
    idle(3);

    // Config offered during RUN is ignored, then accepted in IDLE.
    cyc(0, 1, 0, 1, 3, 0);
    idle(3);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 7, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 7, 0);
    idle(16);
    cyc(0, 0, 1, 0, 0, 0);
    idle(2);

    // Reset mid-run restores the default divisor.
    cyc(0, 1, 0, 0, 0, 0);
    idle(4);
    cyc(1, 0, 0, 0, 0, 0);
    idle(2);
    cyc(0, 1, 0, 0, 0, 0);
    idle(10);
    cyc(0, 0, 1, 0, 0, 0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit r, st, sp, cv;
      r  = ($urandom_range(0, 299) == 0);
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 24) == 0);
      cv = ($urandom_range(0, 3) == 0);
      cyc(r, st, sp, cv, $urandom_range(0, 7), $urandom_range(0, 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/divider_ctrl.md
Name: divider_ctrl

Overview:
- Programmable controller for the divide-by-N tick generator used as a clock-enable source in the datapath.
- Accepts a divisor and burst-length configuration through a valid/ready handshake, then sequences start/stop of the tick stream.
- Reports busy and done status and a running tick count.
- Replaces the fixed divide-by-3 pulse wherever software or another FSM needs a configurable tick.

Parameters:
- WIDTH, 8, width of the divisor register and of cfg_div.
- CNT_W, 16, width of the burst length and of tick_count.
- DEFAULT_DIV, 3, divisor loaded at reset.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  controller can accept configuration; high only in IDLE.
- cfg_div  in  WIDTH  divisor N; 0 and 1 both mean tick every cycle.
- cfg_burst  in  CNT_W  number of ticks per run; 0 means continuous.
- start  in  1  begin a run; level sampled each cycle.
- stop  in  1  abort a run; level sampled each cycle.
- tick  out  1  one-cycle clock-enable pulse.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle pulse when a burst completes normally.
- tick_count  out  CNT_W  ticks issued in the current or last run.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset results, visible the cycle after the reset edge:
  - state = IDLE; div_q = DEFAULT_DIV; burst_q = 0; phase = 0; tick_count = 0.
  - tick = 0, done = 0, busy = 0, cfg_ready = 1.
  - Reset mid-run aborts immediately, with no done pulse.
- State encoding: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10. The unused encoding 2'b11 goes to IDLE on the next edge.
- Config handshake:
  - Transfer when cfg_valid && cfg_ready, latching cfg_div into div_q and cfg_burst into burst_q.
  - cfg_ready = (state == IDLE), combinational from state.
  - In RUN or DONE, cfg_valid is ignored and the registers hold.
- IDLE:
  - If start is high, go to RUN next cycle, clear phase and tick_count.
  - If a config transfer happens in the same cycle as start, the run uses the newly latched values.
- RUN:
  - tick = (state == RUN) && (phase == 0). This is a Moore output, so the first tick appears in the cycle after start is sampled.
  - Effective divisor Ne = max(div_q, 1).
  - phase increments each cycle and wraps from Ne-1 to 0, so ticks occur every Ne cycles.
  - tick_count increments on every edge where tick = 1, saturating at all-ones.
  - If burst_q != 0 and tick = 1 and tick_count + 1 == burst_q, go to DONE.
  - start is ignored while in RUN.
- Stop:
  - stop high in RUN goes to IDLE next cycle, with no done pulse.
  - If stop coincides with a tick, that tick is still output and counted.
  - stop beats burst completion: no DONE, no done pulse.
  - stop in IDLE or DONE has no effect.
- DONE:
  - done = 1 for exactly one cycle; tick = 0.
  - Unconditionally go to IDLE next.
- tick_count holds its value after stop or done until the next start clears it.
- Outputs tick, done, busy and cfg_ready are combinational decodes of the registered state and phase only; there is no combinational path from the inputs.

Test Plan:
- Reset, then start pulse at cycle 0, defaults (div 3, burst 0) -> tick high in cycles 1, 4, 7, 10; busy high from cycle 1; tick_count = 4 after cycle 10; done never asserted.
- In IDLE, cfg_div = 5 and cfg_burst = 2 with cfg_valid, plus start in the same cycle 0 -> ticks in cycles 1 and 6; done in cycle 7; busy low in cycle 8; tick_count = 2 and held.
- cfg_div = 0, cfg_burst = 3, then start -> ticks in cycles 1, 2, 3; done in cycle 4; cfg_ready low during cycles 1–4.
- Running with div 4 and continuous burst, assert stop in the same cycle as the 3rd tick -> that tick is output; tick_count = 3; IDLE next cycle; done stays 0.
- While in RUN, cfg_valid with cfg_div = 7 -> cfg_ready = 0 and the tick period stays unchanged. After stopping, the same offer is accepted in IDLE and the next run ticks every 7 cycles.
- reset asserted mid-run at cycle 5 -> from cycle 6: tick = 0, busy = 0, tick_count = 0, div_q back to 3 (verified by the next start ticking every 3 cycles).
